hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised in-order pipeline hazard unit for the RV32 core family.
- Sits beside decode and tracks destination registers of every in-flight instruction past decode in a DEPTH-slot shift register.
- From that state it raises the decode stall, produces per-source forwarding selects, and applies branch/jump redirect flushes.
- Generalises the fixed five-stage arrangement to any depth, with optional forwarding, configurable load-use latency and a saturating stall counter.

Parameters:
- DEPTH, 3: tracked slots after decode. Slot 0 = result of execute; slot DEPTH-1 = writeback. Range 2..8.
- REG_AW, 5: register index width.
- FWD_EN, 1: 1 = forward from any ready slot; 0 = stall until writeback.
- LOAD_SLOT, 1: first slot in which a load result is forwardable. Range 1..DEPTH-1.
- RF_WRITE_FIRST, 1: 1 = regfile returns the same-cycle writeback value, so a slot DEPTH-1 match needs no stall or forward.
- FLUSH_SLOTS, 0: number of youngest slots (0..FLUSH_SLOTS-1) cleared on FLUSH. Range 0..DEPTH-1.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- ID_VALID  in  1  decode holds a real instruction.
- ID_RS1_SEL  in  REG_AW  source 1 index.
- ID_RS2_SEL  in  REG_AW  source 2 index.
- ID_RS1_USED  in  1  source 1 is read.
- ID_RS2_USED  in  1  source 2 is read.
- ID_RD_SEL  in  REG_AW  destination index.
- ID_REGWRT  in  1  instruction writes rd.
- ID_MEMRD  in  1  instruction is a load.
- FLUSH  in  1  redirect taken this cycle.
- STALL  out  1  hold fetch/decode; insert a bubble into slot 0.
- ISSUE  out  1  decode instruction enters slot 0 this edge.
- FWD1_SEL  out  clog2(DEPTH+1)  0 = regfile; k = value from slot k-1.
- FWD2_SEL  out  clog2(DEPTH+1)  same encoding for source 2.
- INFLIGHT  out  clog2(DEPTH+1)  count of valid writing slots.
- STALL_CNT  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot state: {v, rd, ld}. Every clock, slot i+1 <= slot i, so the pipeline past decode never stalls.
- Slot 0 <= {1, ID_RD_SEL, ID_MEMRD} when ISSUE && ID_REGWRT && ID_RD_SEL != 0; otherwise slot 0 <= {0, 0, 0}.
- ISSUE = ID_VALID && !STALL && !FLUSH (combinational).
- Match rule, per used source s with s != 0: the youngest valid slot k with rd == s wins, and only that slot is considered.
- Slot k is ready when !ld || k >= LOAD_SLOT.
- Stall per source when its winning match m has:
  - FWD_EN=1: !ready(m).
  - FWD_EN=0: m < DEPTH-1.
  - Either mode: m == DEPTH-1 && !RF_WRITE_FIRST.
- STALL = ID_VALID && !FLUSH && (stall_src1 || stall_src2). All combinational from current state; no latency.
- FWD sel:
  - m+1 when FWD_EN && ready(m) && !(m == DEPTH-1 && RF_WRITE_FIRST).
  - Otherwise 0.
  - 0 when the source is unused, is x0, has no match, or STALL is high.
- FLUSH:
  - Slot 0 receives a bubble.
  - Slots 1..FLUSH_SLOTS (the shifted images of old slots 0..FLUSH_SLOTS-1) are cleared on the same edge.
  - Older slots shift normally.
  - FLUSH overrides STALL (STALL forced 0).
- INFLIGHT = popcount of slot valids, registered state only.
- STALL_CNT increments on every cycle STALL=1 and saturates at all-ones. It is cleared only by RESET.
- RESET: all slots invalid, rd/ld=0, STALL_CNT=0. Consequently STALL=0, ISSUE=ID_VALID, FWD sels=0, INFLIGHT=0 in the cycle after reset. RESET mid-stall drops all tracked hazards.
- x0 never creates or matches a hazard.
- A source matching the same rd in several slots uses only the youngest.

Test Plan:
- Defaults; issue ADD rd=5, then SUB rs1=5 next cycle -> STALL=0, FWD1_SEL=1. Two cycles later, rs1=5 -> FWD1_SEL=2.
- Defaults; LW rd=7, then ADD rs2=7 -> STALL=1 for exactly 1 cycle, ISSUE=0, then FWD2_SEL=2 and STALL_CNT=1.
- FWD_EN=0, DEPTH=3, RF_WRITE_FIRST=1; ADD rd=3, then a user of rs1=3 -> STALL high 2 cycles, then ISSUE with FWD1_SEL=0.
- Youngest wins: ADD rd=4, then LW rd=4, then user rs1=4 -> stall on the load. Must not forward the older ADD from slot 1.
- FLUSH_SLOTS=1; slot 0 holds rd=9, FLUSH=1 with a rs1=9 user in decode -> STALL=0, ISSUE=0. Next cycle INFLIGHT excludes rd=9 and a rs1=9 user gets FWD1_SEL=0.
- Hold a load-use stall continuously with CNT_W=2 -> STALL_CNT saturates at 3. RESET pulse -> STALL_CNT=0, INFLIGHT=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-order pipeline hazard scoreboard with stall, forwarding and flush
//
// Sits beside decode and records the destination register of every
// instruction past decode in a DEPTH-slot shift register. Slot 0 holds the
// execute result and slot DEPTH-1 holds writeback. The slots advance every
// clock, so the pipeline behind decode never stalls. From the slot contents
// the block derives the decode stall, the forwarding selects for both
// sources, and the redirect flush of the youngest slots.
//
// Ports:
//   CLK          clock
//   RESET        synchronous active-high reset
//   ID_VALID     decode holds a real instruction
//   ID_RS1_SEL   source 1 register index
//   ID_RS2_SEL   source 2 register index
//   ID_RS1_USED  source 1 is read
//   ID_RS2_USED  source 2 is read
//   ID_RD_SEL    destination register index
//   ID_REGWRT    instruction writes its destination
//   ID_MEMRD     instruction is a load
//   FLUSH        branch/jump redirect taken this cycle
//   STALL        hold fetch/decode, bubble enters slot 0
//   ISSUE        decode instruction enters slot 0 on this edge
//   FWD1_SEL     source 1 select: 0 = regfile, k = slot k-1
//   FWD2_SEL     source 2 select, same encoding
//   INFLIGHT     number of valid slots
//   STALL_CNT    saturating count of stall cycles

module hazard_scoreboard #(
    parameter int DEPTH          = 3,
    parameter int REG_AW         = 5,
    parameter int FWD_EN         = 1,
    parameter int LOAD_SLOT      = 1,
    parameter int RF_WRITE_FIRST = 1,
    parameter int FLUSH_SLOTS    = 0,
    parameter int CNT_W          = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ID_VALID,
    input  logic [REG_AW-1:0]            ID_RS1_SEL,
    input  logic [REG_AW-1:0]            ID_RS2_SEL,
    input  logic                         ID_RS1_USED,
    input  logic                         ID_RS2_USED,
    input  logic [REG_AW-1:0]            ID_RD_SEL,
    input  logic                         ID_REGWRT,
    input  logic                         ID_MEMRD,
    input  logic                         FLUSH,
    output logic                         STALL,
    output logic                         ISSUE,
    output logic [$clog2(DEPTH+1)-1:0]   FWD1_SEL,
    output logic [$clog2(DEPTH+1)-1:0]   FWD2_SEL,
    output logic [$clog2(DEPTH+1)-1:0]   INFLIGHT,
    output logic [CNT_W-1:0]             STALL_CNT
);

    localparam int SW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  slot_v;
    logic [DEPTH-1:0]  slot_ld;
    logic [REG_AW-1:0] slot_rd [DEPTH];
    logic [CNT_W-1:0]  stall_cnt;

    logic [REG_AW-1:0] src_sel [2];
    logic [1:0]        src_used;
    logic [1:0]        src_hit;
    logic [1:0]        src_ready;
    logic [1:0]        src_stall;
    logic [1:0]        src_fwd_ok;
    logic [SW-1:0]     src_idx [2];

    logic              stall_int;
    logic              issue_int;
    logic [SW-1:0]     inflight;

    // Per-source hazard evaluation. Slots are scanned oldest to youngest so
    // the youngest matching slot is the last one written and alone decides
    // stall and forwarding; older matches with the same rd are shadowed.
    always_comb begin
        src_sel[0] = ID_RS1_SEL;
        src_sel[1] = ID_RS2_SEL;
        src_used   = {ID_RS2_USED, ID_RS1_USED};
        src_hit    = '0;
        src_ready  = '0;
        src_stall  = '0;
        src_fwd_ok = '0;
        src_idx[0] = '0;
        src_idx[1] = '0;
        for (int j = 0; j < 2; j++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (src_used[j] && (src_sel[j] != '0) && slot_v[k] &&
                    (slot_rd[k] == src_sel[j])) begin
                    src_hit[j]   = 1'b1;
                    src_idx[j]   = SW'(k);
                    src_ready[j] = !slot_ld[k] || (k >= LOAD_SLOT);
                end
            end
            if (src_hit[j]) begin
                if (int'(src_idx[j]) == DEPTH - 1) begin
                    // Writeback slot: a write-first regfile already returns
                    // the new value, otherwise decode must wait one more cycle.
                    src_stall[j]  = (RF_WRITE_FIRST == 0);
                    src_fwd_ok[j] = FWD_EN != 0 && RF_WRITE_FIRST == 0 && src_ready[j];
                end else if (FWD_EN != 0) begin
                    src_stall[j]  = !src_ready[j];
                    src_fwd_ok[j] = src_ready[j];
                end else begin
                    src_stall[j]  = 1'b1;
                end
            end
        end
    end

    // A redirect kills the decode instruction, so it must never be held.
    assign stall_int = ID_VALID && !FLUSH && (|src_stall);
    assign issue_int = ID_VALID && !stall_int && !FLUSH;

    assign STALL     = stall_int;
    assign ISSUE     = issue_int;
    assign FWD1_SEL  = (src_fwd_ok[0] && !stall_int) ? SW'(src_idx[0] + SW'(1)) : '0;
    assign FWD2_SEL  = (src_fwd_ok[1] && !stall_int) ? SW'(src_idx[1] + SW'(1)) : '0;
    assign STALL_CNT = stall_cnt;
    assign INFLIGHT  = inflight;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight = inflight + SW'(slot_v[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_v    <= '0;
            slot_ld   <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd[i] <= '0;
            end
        end else begin
            // Slots 1..FLUSH_SLOTS receive the images of the youngest
            // instructions, which are wrong-path on a redirect.
            for (int i = 1; i < DEPTH; i++) begin
                if (FLUSH && (i <= FLUSH_SLOTS)) begin
                    slot_v[i]  <= 1'b0;
                    slot_rd[i] <= '0;
                    slot_ld[i] <= 1'b0;
                end else begin
                    slot_v[i]  <= slot_v[i-1];
                    slot_rd[i] <= slot_rd[i-1];
                    slot_ld[i] <= slot_ld[i-1];
                end
            end
            // x0 writes are dropped here so they can never match later.
            if (issue_int && ID_REGWRT && (ID_RD_SEL != '0)) begin
                slot_v[0]  <= 1'b1;
                slot_rd[0] <= ID_RD_SEL;
                slot_ld[0] <= ID_MEMRD;
            end else begin
                slot_v[0]  <= 1'b0;
                slot_rd[0] <= '0;
                slot_ld[0] <= 1'b0;
            end
            if (stall_int && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       e_stall;
        logic       e_issue;
        logic [2:0] e_f1;
        logic [2:0] e_f2;
        logic [2:0] e_infl;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic       u1 = 1'b0;
    logic       u2 = 1'b0;
    logic [4:0] rd = '0;
    logic       wr = 1'b0;
    logic       ld = 1'b0;
    logic       flush = 1'b0;

    logic        d_stall, d_issue;
    logic [1:0]  d_f1, d_f2, d_infl;
    logic [15:0] d_cnt;
    logic        n_stall, n_issue;
    logic [1:0]  n_f1, n_f2, n_infl;
    logic [15:0] n_cnt;
    logic        c_stall, c_issue;
    logic [1:0]  c_f1, c_f2, c_infl;
    logic [15:0] c_cnt;
    logic        s_stall, s_issue;
    logic [2:0]  s_f1, s_f2, s_infl;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    hazard_scoreboard u_def (
        .CLK(clk), .RESET(reset), .ID_VALID(id_valid), .ID_RS1_SEL(rs1), .ID_RS2_SEL(rs2),
        .ID_RS1_USED(u1), .ID_RS2_USED(u2), .ID_RD_SEL(rd), .ID_REGWRT(wr), .ID_MEMRD(ld),
        .FLUSH(flush), .STALL(d_stall), .ISSUE(d_issue), .FWD1_SEL(d_f1), .FWD2_SEL(d_f2),
        .INFLIGHT(d_infl), .STALL_CNT(d_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0)) u_nof (
        .CLK(clk), .RESET(reset), .ID_VALID(id_valid), .ID_RS1_SEL(rs1), .ID_RS2_SEL(rs2),
        .ID_RS1_USED(u1), .ID_RS2_USED(u2), .ID_RD_SEL(rd), .ID_REGWRT(wr), .ID_MEMRD(ld),
        .FLUSH(flush), .STALL(n_stall), .ISSUE(n_issue), .FWD1_SEL(n_f1), .FWD2_SEL(n_f2),
        .INFLIGHT(n_infl), .STALL_CNT(n_cnt)
    );

    hazard_scoreboard #(.FLUSH_SLOTS(1)) u_cfg (
        .CLK(clk), .RESET(reset), .ID_VALID(id_valid), .ID_RS1_SEL(rs1), .ID_RS2_SEL(rs2),
        .ID_RS1_USED(u1), .ID_RS2_USED(u2), .ID_RD_SEL(rd), .ID_REGWRT(wr), .ID_MEMRD(ld),
        .FLUSH(flush), .STALL(c_stall), .ISSUE(c_issue), .FWD1_SEL(c_f1), .FWD2_SEL(c_f2),
        .INFLIGHT(c_infl), .STALL_CNT(c_cnt)
    );

    hazard_scoreboard #(.DEPTH(6), .LOAD_SLOT(5), .CNT_W(2)) u_sat (
        .CLK(clk), .RESET(reset), .ID_VALID(id_valid), .ID_RS1_SEL(rs1), .ID_RS2_SEL(rs2),
        .ID_RS1_USED(u1), .ID_RS2_USED(u2), .ID_RD_SEL(rd), .ID_REGWRT(wr), .ID_MEMRD(ld),
        .FLUSH(flush), .STALL(s_stall), .ISSUE(s_issue), .FWD1_SEL(s_f1), .FWD2_SEL(s_f2),
        .INFLIGHT(s_infl), .STALL_CNT(s_cnt)
    );

    function automatic step_t mk(int v, int a1, int e1, int a2, int e2, int d, int w, int l,
                                 int f, int es, int ei, int ef1, int ef2, int einf);
        step_t s;
        s.v = v[0];   s.rs1 = a1[4:0]; s.u1 = e1[0]; s.rs2 = a2[4:0]; s.u2 = e2[0];
        s.rd = d[4:0]; s.wr = w[0];    s.ld = l[0];  s.fl = f[0];
        s.e_stall = es[0]; s.e_issue = ei[0];
        s.e_f1 = ef1[2:0]; s.e_f2 = ef2[2:0]; s.e_infl = einf[2:0];
        return s;
    endfunction

    function automatic logic [15:0] exp_word(step_t s);
        return {5'd0, s.e_stall, s.e_issue, s.e_f1, s.e_f2, s.e_infl};
    endfunction

    task automatic apply(input step_t s);
        id_valid = s.v; rs1 = s.rs1; u1 = s.u1; rs2 = s.rs2; u2 = s.u2;
        rd = s.rd; wr = s.wr; ld = s.ld; flush = s.fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step_t tbl [$];
        logic [15:0] got, want;
        do_reset();
        checks++;
        if ({d_cnt, n_infl, c_infl, s_infl, s_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d infl=%0d/%0d/%0d satcnt=%0d required all 0",
                     d_cnt, n_infl, c_infl, s_infl, s_cnt);
        end
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            if (i > 0) @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(exp_word(tbl[i]));
            #1;
            got  = {5'd0, d_stall, d_issue, 1'b0, d_f1, 1'b0, d_f2, 1'b0, d_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_forward();
        step_t tbl [$];
        logic [15:0] got, want;
        do_reset();
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2));
        tbl.push_back(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 2, 2));
        tbl.push_back(mk(1, 0, 1, 6, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(exp_word(tbl[i]));
            #1;
            got  = {5'd0, d_stall, d_issue, 1'b0, d_f1, 1'b0, d_f2, 1'b0, d_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL forward step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        step_t tbl [$];
        logic [15:0] got, want;
        do_reset();
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 1, 0, 2, 1));
        tbl.push_back(mk(1, 8, 1, 7, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2));
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(exp_word(tbl[i]));
            #1;
            got  = {5'd0, d_stall, d_issue, 1'b0, d_f1, 1'b0, d_f2, 1'b0, d_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use step %0d: got %h required %h", i, got, want);
            end
        end
        checks++;
        if (d_cnt !== 16'd1) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d required 1", d_cnt);
        end
    endtask

    task automatic test_no_forward();
        step_t tbl [$];
        logic [15:0] got, want;
        do_reset();
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(exp_word(tbl[i]));
            #1;
            got  = {5'd0, n_stall, n_issue, 1'b0, n_f1, 1'b0, n_f2, 1'b0, n_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL no_forward step %0d: got %h required %h", i, got, want);
            end
        end
        checks++;
        if (n_cnt !== 16'd2) begin
            errors++;
            $display("FAIL no_forward_cnt: got %0d required 2", n_cnt);
        end
    endtask

    task automatic test_youngest();
        step_t tbl [$];
        logic [15:0] got, want;
        do_reset();
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 4, 1, 4, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2));
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(exp_word(tbl[i]));
            #1;
            got  = {5'd0, d_stall, d_issue, 1'b0, d_f1, 1'b0, d_f2, 1'b0, d_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL youngest step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_flush();
        step_t tbl [$];
        logic [15:0] got, want;
        do_reset();
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 9, 1, 11, 1, 10, 1, 0, 1, 0, 0, 1, 2, 2));
        tbl.push_back(mk(1, 9, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(exp_word(tbl[i]));
            #1;
            got  = {5'd0, c_stall, c_issue, 1'b0, c_f1, 1'b0, c_f2, 1'b0, c_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL flush step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_saturate();
        step_t tbl [$];
        int ecnt [7] = '{0, 0, 1, 2, 3, 3, 0};
        int est  [7] = '{0, 1, 1, 1, 1, 1, 0};
        int einf [7] = '{0, 1, 1, 1, 1, 1, 0};
        logic [15:0] got, want;
        do_reset();
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 7; i++) begin
            tbl.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            reset = (i == 5);
            exp_q.push_back({9'd0, est[i][0], ~est[i][0], ecnt[i][1:0], einf[i][2:0]});
            #1;
            got  = {9'd0, s_stall, s_issue, s_cnt, s_infl};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL saturate step %0d: got %h required %h", i, got, want);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_no_forward();
        test_youngest();
        test_flush();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
